// File: rtl/posit_add_pkg.sv
// Shared types and helpers for the posit adder normalisation stage.
// Holds the stage FSM encoding, the default scale saturation limits and
// the regime-length rule used when deriving the rounding-stage fields.
package posit_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int POSIT_N   = 32;
  localparam int POSIT_ES  = 2;
  localparam int MAX_SCALE = (POSIT_N - 2) << POSIT_ES;
  localparam int MIN_SCALE = -MAX_SCALE;

  // Largest representable scale magnitude (maxpos/minpos) for a given format.
  function automatic int scale_limit(int n, int es);
    return (n - 2) << es;
  endfunction

  // Regime run length for a clamped scale: k = scale >>> es,
  // k >= 0 gives k+1, k < 0 gives -k, capped at n-2.
  function automatic int regime_len(int le, int es, int n);
    int k;
    int r;
    k = le >>> es;
    r = (k >= 0) ? (k + 1) : -k;
    if (r > n - 2) r = n - 2;
    return r;
  endfunction

endpackage

// File: rtl/posit_add_normalise_lzc.sv
// Leading-zero counter over a W-bit vector.
// count is the number of zeros above the first set bit; all_zero flags an
// empty vector (count is then meaningless).
module posit_lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Scan from the MSB; stop counting at the first one.
  always_comb begin
    count    = '0;
    all_zero = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (all_zero) begin
        if (value[i]) all_zero = 1'b0;
        else          count    = count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/posit_add_normalise.sv
// Normalisation stage of the posit adder/subtractor, feeding rounding.
// Absorbs a carry out of the aligned sum or removes its leading zeros, then
// saturates the scale and derives LE_O / E_O / R_O / Add_Mant_N.
// Build option: define POSIT_NORM_FASTLZC_EN to normalise fully in the
// capture cycle using the leading-zero counter; otherwise the mantissa is
// shifted left by at most STEP bits per SHIFT cycle. Results are identical.
module posit_add_normalise
  import posit_add_pkg::*;
#(
  parameter int N    = 32,
  parameter int ES   = 2,
  parameter int RS   = $clog2(N),
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      IN1,
  input  logic [N-1:0]      IN2,
  input  logic              inf1,
  input  logic              inf2,
  input  logic              zero1,
  input  logic              zero2,
  input  logic              LS_I,
  input  logic [ES+RS+1:0]  LE_I,
  input  logic [N:0]        Add_Mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ES+RS:0]    LE_O,
  output logic [ES-1:0]     E_O,
  output logic [RS:0]       R_O,
  output logic [N:0]        Add_Mant_O,
  output logic [N-1:0]      Add_Mant_N,
  output logic              LS,
  output logic [N-1:0]      IN1_O,
  output logic [N-1:0]      IN2_O,
  output logic              inf1_O,
  output logic              inf2_O,
  output logic              zero1_O,
  output logic              zero2_O,
  output logic              mant_zero
);

  // Internal scale carries two extra bits so LE_I+1 and the shift
  // decrements never wrap before saturation.
  localparam int SW = ES + RS + 4;
  localparam int LW = ES + RS + 1;
  localparam logic signed [SW-1:0] scale_hi = SW'(scale_limit(N, ES));
  localparam logic signed [SW-1:0] scale_lo = -scale_hi;

  state_t                state;
  logic [N-1:0]          mant;
  logic signed [SW-1:0]  scale;
  logic [N-1:0]          lzc_in;
  logic [RS-1:0]         lz;
  logic                  lz_all_zero;
  logic [N-1:0]          nxt_mant;
  logic signed [SW-1:0]  nxt_scale;
  logic                  nxt_done;
  logic signed [SW-1:0]  le_ext;
  logic signed [SW-1:0]  sat_scale;
  logic [RS:0]           sat_regime;
  int                    shift_amt;

  // The counter looks at the incoming sum while idle and at the working
  // mantissa while shifting, so one instance serves both phases.
  assign lzc_in = (state == IDLE) ? Add_Mant[N-1:0] : mant;
  assign le_ext = {{(SW - LW - 1){LE_I[LW]}}, LE_I};

  posit_lzc #(
    .W  (N),
    .CW (RS)
  ) u_lzc (
    .value    (lzc_in),
    .count    (lz),
    .all_zero (lz_all_zero)
  );

  // Next mantissa/scale and whether that result is already normalised.
  always_comb begin
    nxt_mant  = mant;
    nxt_scale = scale;
    nxt_done  = 1'b0;
    shift_amt = 0;
    case (state)
      IDLE: begin
        nxt_mant  = Add_Mant[N-1:0];
        nxt_scale = le_ext;
        if (Add_Mant[N]) begin
          nxt_mant  = Add_Mant[N:1];
          nxt_scale = le_ext + SW'(1);
          nxt_done  = 1'b1;
        end else if (lz_all_zero) begin
          nxt_mant  = '0;
          nxt_scale = scale_lo;
          nxt_done  = 1'b1;
        end else if (Add_Mant[N-1]) begin
          nxt_done  = 1'b1;
        end else begin
`ifdef POSIT_NORM_FASTLZC_EN
          nxt_mant  = Add_Mant[N-1:0] << lz;
          nxt_scale = le_ext - SW'(lz);
          nxt_done  = 1'b1;
`endif
        end
      end
      SHIFT: begin
        // The final step is trimmed to the remaining zeros so the hidden
        // bit lands exactly at [N-1].
        shift_amt = (int'(lz) < STEP) ? int'(lz) : STEP;
        nxt_mant  = mant << shift_amt;
        nxt_scale = scale - SW'(shift_amt);
        nxt_done  = (int'(lz) <= STEP);
      end
      default: ;
    endcase
  end

  // Clamp to minpos/maxpos and derive the regime length of the result.
  always_comb begin
    sat_scale = nxt_scale;
    if (nxt_scale > scale_hi)      sat_scale = scale_hi;
    else if (nxt_scale < scale_lo) sat_scale = scale_lo;
    sat_regime = (RS + 1)'(regime_len(int'(sat_scale), ES, N));
  end

  // Stage FSM: capture, iterate, then hold the result until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      mant       <= '0;
      scale      <= '0;
      LE_O       <= '0;
      R_O        <= '0;
      Add_Mant_O <= '0;
      LS         <= 1'b0;
      IN1_O      <= '0;
      IN2_O      <= '0;
      inf1_O     <= 1'b0;
      inf2_O     <= 1'b0;
      zero1_O    <= 1'b0;
      zero2_O    <= 1'b0;
      mant_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mant       <= nxt_mant;
            scale      <= nxt_scale;
            Add_Mant_O <= Add_Mant;
            LS         <= LS_I;
            IN1_O      <= IN1;
            IN2_O      <= IN2;
            inf1_O     <= inf1;
            inf2_O     <= inf2;
            zero1_O    <= zero1;
            zero2_O    <= zero2;
            mant_zero  <= lz_all_zero & ~Add_Mant[N];
            in_ready   <= 1'b0;
            if (nxt_done) begin
              state     <= DONE;
              out_valid <= 1'b1;
              LE_O      <= sat_scale[LW-1:0];
              R_O       <= sat_regime;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          mant  <= nxt_mant;
          scale <= nxt_scale;
          if (nxt_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            LE_O      <= sat_scale[LW-1:0];
            R_O       <= sat_regime;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign E_O        = LE_O[ES-1:0];
  assign Add_Mant_N = mant;

endmodule

// File: tb/tb_posit_add_normalise.sv
// Self-checking bench for posit_add_normalise (N=32, ES=2, STEP=4).
// A behavioural model computes each beat's expected result from the MSB
// position of the sum; a negedge monitor compares every valid output cycle.
`timescale 1ns/1ps
module tb_posit_add_normalise;

  localparam int N    = 32;
  localparam int ES   = 2;
  localparam int RS   = 5;
  localparam int STEP = 4;
  localparam int LIM  = (N - 2) << ES;
`ifdef POSIT_NORM_FASTLZC_EN
  localparam int SHIFT_LAT  = 1;
  localparam int SHIFT_LAT2 = 1;
`else
  localparam int SHIFT_LAT  = 7;
  localparam int SHIFT_LAT2 = 5;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      IN1 = '0, IN2 = '0;
  logic              inf1 = 0, inf2 = 0, zero1 = 0, zero2 = 0, LS_I = 0;
  logic [ES+RS+1:0]  LE_I = '0;
  logic [N:0]        Add_Mant = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ES+RS:0]    LE_O;
  logic [ES-1:0]     E_O;
  logic [RS:0]       R_O;
  logic [N:0]        Add_Mant_O;
  logic [N-1:0]      Add_Mant_N;
  logic              LS;
  logic [N-1:0]      IN1_O, IN2_O;
  logic              inf1_O, inf2_O, zero1_O, zero2_O, mant_zero;

  always #5 clk = ~clk;

  posit_add_normalise #(.N(N), .ES(ES), .RS(RS), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .IN1(IN1), .IN2(IN2), .inf1(inf1), .inf2(inf2), .zero1(zero1), .zero2(zero2),
    .LS_I(LS_I), .LE_I(LE_I), .Add_Mant(Add_Mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .LE_O(LE_O), .E_O(E_O), .R_O(R_O), .Add_Mant_O(Add_Mant_O), .Add_Mant_N(Add_Mant_N),
    .LS(LS), .IN1_O(IN1_O), .IN2_O(IN2_O), .inf1_O(inf1_O), .inf2_O(inf2_O),
    .zero1_O(zero1_O), .zero2_O(zero2_O), .mant_zero(mant_zero)
  );

  typedef struct {
    logic [N-1:0] mant_n;
    int           le;
    int           e;
    int           r;
    bit           mz;
    int           lat;
    logic [N:0]   am;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic [3:0]   flags;
    logic         ls;
    int           acc;
    bit           seen;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;
  bit   rdy_rand = 0;
  exp_t exp_q[$];
  logic [N-1:0] last_mant;
  int   last_le, last_e, last_r, last_lat, cur_lat;
  logic last_mz;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Expected result: locate the MSB, move it to [N-1], adjust the scale by
  // the same distance, saturate, then apply the regime rule.
  function automatic exp_t model(logic [N:0] am, int le_i);
    exp_t x;
    int   p, s, k, q;
    p = -1;
    for (int i = 0; i <= N; i++) if (am[i]) p = i;
    x.lat = 1;
    x.am = am; x.seen = 0; x.acc = 0; x.in1 = '0; x.in2 = '0; x.flags = '0; x.ls = 0;
    if (p < 0) begin
      x.mz = 1; x.mant_n = '0; s = -LIM;
    end else begin
      x.mz = 0;
      if (p == N) x.mant_n = am[N:1];
      else        x.mant_n = am[N-1:0] << (N - 1 - p);
      s = le_i + (p - (N - 1));
`ifndef POSIT_NORM_FASTLZC_EN
      if (p < N - 1) x.lat = 1 + (N - 1 - p + STEP - 1) / STEP;
`endif
    end
    if (s > LIM)  s = LIM;
    if (s < -LIM) s = -LIM;
    x.le = s;
    q = 1 << ES;
    x.e = s & (q - 1);
    k = (s >= 0) ? s / q : -((-s + q - 1) / q);
    x.r = (k >= 0) ? k + 1 : -k;
    if (x.r > N - 2) x.r = N - 2;
    return x;
  endfunction

  function automatic logic [N:0] rand_mant();
    logic [N:0] m;
    int p;
    p = int'($urandom_range(0, N + 2));
    if (p > N) return '0;
    m = {1'($urandom), $urandom};
    m = m & ((33'd1 << p) - 33'd1);
    m[p] = 1'b1;
    return m;
  endfunction

  // Compare process: every cycle with out_valid is checked against the
  // oldest outstanding expectation; accepted inputs enqueue new ones.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("Add_Mant_N", Add_Mant_N, e.mant_n);
          chk("LE_O", $signed(LE_O), e.le);
          chk("E_O", E_O, e.e);
          chk("R_O", R_O, e.r);
          chk("mant_zero", mant_zero, e.mz);
          chk("Add_Mant_O", Add_Mant_O, e.am);
          chk("IN_pass", {IN1_O, IN2_O}, {e.in1, e.in2});
          chk("flag_pass", {inf1_O, inf2_O, zero1_O, zero2_O, LS}, {e.flags, e.ls});
          chk("in_ready_busy", in_ready, 0);
          if (!e.seen) begin
            cur_lat = ncyc - e.acc;
            chk("latency", cur_lat, e.lat);
            exp_q[0].seen = 1;
          end
          if (out_ready) begin
            last_mant = Add_Mant_N; last_le = $signed(LE_O); last_e = E_O;
            last_r = R_O; last_mz = mant_zero; last_lat = cur_lat;
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(Add_Mant, int'($signed(LE_I)));
        e.in1 = IN1; e.in2 = IN2; e.flags = {inf1, inf2, zero1, zero2}; e.ls = LS_I;
        e.acc = ncyc;
        exp_q.push_back(e);
      end
    end
  end

  // Random backpressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic start_beat(logic [N:0] am, int le);
    int n;
    Add_Mant = am; LE_I = 9'(le);
    IN1 = $urandom; IN2 = $urandom;
    {inf1, inf2, zero1, zero2} = 4'($urandom); LS_I = 1'($urandom);
    in_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    Add_Mant = {1'($urandom), $urandom}; LE_I = 9'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    chk("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    exp_t m;
    logic [45:0] snap;
    int n;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_LE_O", LE_O, 0);
    chk("rst_R_O", R_O, 0);
    chk("rst_E_O", E_O, 0);
    chk("rst_Add_Mant_N", Add_Mant_N, 0);
    chk("rst_Add_Mant_O", Add_Mant_O, 0);
    chk("rst_mant_zero", mant_zero, 0);
    chk("rst_pass", {IN1_O, IN2_O, LS, inf1_O, inf2_O, zero1_O, zero2_O}, 0);
    @(posedge clk); #1;

    // Pin the model against hand-worked values.
    m = model(33'h1_0000_0000, 5);
    chk("model_carry_mant", m.mant_n, 32'h8000_0000);
    chk("model_carry_le", m.le, 6);
    chk("model_carry_e", m.e, 2);
    chk("model_carry_r", m.r, 2);
    m = model(33'h0_0000_0100, 0);
    chk("model_shift_le", m.le, -23);
    chk("model_shift_r", m.r, 6);
    chk("model_shift_lat", m.lat, SHIFT_LAT);
    m = model(33'h0, 17);
    chk("model_zero_le", m.le, -120);
    chk("model_zero_mz", m.mz, 1);
    m = model(33'h1_0000_0000, 120);
    chk("model_sat_r", m.r, 30);

    // Directed beats from the worked examples.
    start_beat(33'h1_0000_0000, 5); drain();
    chk("carry_mant", last_mant, 32'h8000_0000);
    chk("carry_le", last_le, 6);
    chk("carry_e", last_e, 2);
    chk("carry_r", last_r, 2);
    chk("carry_lat", last_lat, 1);

    start_beat(33'h0_0000_0100, 0); drain();
    chk("shift_mant", last_mant, 32'h8000_0000);
    chk("shift_le", last_le, -23);
    chk("shift_r", last_r, 6);
    chk("shift_lat", last_lat, SHIFT_LAT);

    start_beat(33'h0, 33); drain();
    chk("cancel_mz", last_mz, 1);
    chk("cancel_le", last_le, -120);
    chk("cancel_r", last_r, 30);
    chk("cancel_lat", last_lat, 1);

    start_beat(33'h1_0000_0000, 120); drain();
    chk("sat_le", last_le, 120);
    chk("sat_r", last_r, 30);

    start_beat(33'h0_8000_0001, -3); drain();
    start_beat(33'h0_0800_0000, 2); drain();
    start_beat(33'h0_0000_0001, -200); drain();
    start_beat(33'h1_FFFF_FFFF, 255); drain();

    // Backpressure: hold the result for five cycles, with a competing
    // in_valid that must be ignored.
    out_ready = 0;
    start_beat(33'h0_0000_0F00, -7);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_reach_done", out_valid, 1);
    snap = {Add_Mant_N, LE_O, R_O};
    Add_Mant = 33'h1_2345_6789; in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {Add_Mant_N, LE_O, R_O}, snap);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_single", exp_q.size(), 0);
    out_ready = 1;
    @(posedge clk); #1;

    // Reset while a beat is in flight.
    out_ready = 0;
    start_beat(33'h0_0000_0001, 3);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1;
    @(posedge clk); #1;
    start_beat(33'h0_0001_2345, 10); drain();
    chk("postrst_mant", last_mant, 32'h91A2_8000);
    chk("postrst_le", last_le, -5);
    chk("postrst_e", last_e, 3);
    chk("postrst_r", last_r, 2);
    chk("postrst_lat", last_lat, SHIFT_LAT2);

    // Randomised beats with random backpressure.
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      start_beat(rand_mant(), int'($urandom_range(0, 511)) - 256);
      drain();
    end
    rdy_rand = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
